// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if: the two master ports plus the shared slave-side port of the arbiter
interface ahb_master_arbiter_if;
    logic        M0_HBUSREQ, M1_HBUSREQ, M0_HLOCK, M1_HLOCK;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic        M0_HGRANT, M1_HGRANT, M0_HREADY, M1_HREADY;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HMASTER, HREADY;
    logic [2:0]  HSIZE;
    modport slave (
        input  M0_HBUSREQ, M1_HBUSREQ, M0_HLOCK, M1_HLOCK, M0_HADDR, M1_HADDR,
               M0_HTRANS, M1_HTRANS, M0_HWRITE, M1_HWRITE, M0_HSIZE, M1_HSIZE,
               M0_HWDATA, M1_HWDATA, HREADY, HRDATA,
        output M0_HGRANT, M1_HGRANT, M0_HREADY, M1_HREADY, M0_HRDATA, M1_HRDATA,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTLOCK, HMASTER
    );
    modport master (
        output M0_HBUSREQ, M1_HBUSREQ, M0_HLOCK, M1_HLOCK, M0_HADDR, M1_HADDR,
               M0_HTRANS, M1_HTRANS, M0_HWRITE, M1_HWRITE, M0_HSIZE, M1_HSIZE,
               M0_HWDATA, M1_HWDATA, HREADY, HRDATA,
        input  M0_HGRANT, M1_HGRANT, M0_HREADY, M1_HREADY, M0_HRDATA, M1_HRDATA,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTLOCK, HMASTER
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two-master AHB-Lite arbiter with registered grant and split address/data ownership
module ahb_master_arbiter #(
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    ahb_master_arbiter_if.slave bus
);
    logic       grant_q, grant_d, addr_owner_q, addr_owner_d;
    logic       data_owner_q, data_owner_d, lock_q, lock_d;
    logic [1:0] req, lck, htrans_g;
    logic       hold, pick;
    always_comb begin
        req          = {bus.M1_HBUSREQ, bus.M0_HBUSREQ};
        lck          = {bus.M1_HLOCK, bus.M0_HLOCK};
        htrans_g     = grant_q ? bus.M1_HTRANS : bus.M0_HTRANS;
        // BUSY and SEQ are the only transfer types with bit 0 set
        hold         = (lck[grant_q] && req[grant_q]) || htrans_g[0];
        pick         = ROUND_ROBIN
                       ? (req[!grant_q] ? !grant_q : req[grant_q] ? grant_q : DEFAULT_MASTER)
                       : (req[0] ? 1'b0 : req[1] ? 1'b1 : DEFAULT_MASTER);
        grant_d      = bus.HREADY ? (hold ? grant_q : pick) : grant_q;
        addr_owner_d = bus.HREADY ? grant_q : addr_owner_q;
        data_owner_d = bus.HREADY ? addr_owner_q : data_owner_q;
        lock_d       = bus.HREADY ? lck[grant_q] : lock_q;
    end
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q      <= DEFAULT_MASTER;
            addr_owner_q <= DEFAULT_MASTER;
            data_owner_q <= DEFAULT_MASTER;
            lock_q       <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            lock_q       <= lock_d;
        end
    end
    assign bus.M0_HGRANT = !grant_q;
    assign bus.M1_HGRANT = grant_q;
    assign bus.M0_HREADY = bus.HREADY;
    assign bus.M1_HREADY = bus.HREADY;
    assign bus.M0_HRDATA = bus.HRDATA;
    assign bus.M1_HRDATA = bus.HRDATA;
    assign bus.HADDR     = addr_owner_q ? bus.M1_HADDR : bus.M0_HADDR;
    assign bus.HTRANS    = !HRESETn ? 2'b00 : addr_owner_q ? bus.M1_HTRANS : bus.M0_HTRANS;
    assign bus.HWRITE    = addr_owner_q ? bus.M1_HWRITE : bus.M0_HWRITE;
    assign bus.HSIZE     = addr_owner_q ? bus.M1_HSIZE : bus.M0_HSIZE;
    assign bus.HWDATA    = data_owner_q ? bus.M1_HWDATA : bus.M0_HWDATA;
    assign bus.HMASTLOCK = lock_q;
    assign bus.HMASTER   = addr_owner_q;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed scenarios for the two-master arbiter
module tb_ahb_master_arbiter;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    ahb_master_arbiter_if bus();
    ahb_master_arbiter #(.ROUND_ROBIN(1'b1), .DEFAULT_MASTER(1'b0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic quiet();
        bus.M0_HBUSREQ = 1'b0; bus.M1_HBUSREQ = 1'b0;
        bus.M0_HLOCK   = 1'b0; bus.M1_HLOCK   = 1'b0;
        bus.M0_HADDR   = 32'h0; bus.M1_HADDR  = 32'h0;
        bus.M0_HTRANS  = 2'b00; bus.M1_HTRANS = 2'b00;
        bus.M0_HWRITE  = 1'b0; bus.M1_HWRITE  = 1'b0;
        bus.M0_HSIZE   = 3'b010; bus.M1_HSIZE = 3'b010;
        bus.M0_HWDATA  = 32'h1111_1111; bus.M1_HWDATA = 32'h2222_2222;
        bus.HREADY     = 1'b1; bus.HRDATA     = 32'hA5A5_0000;
    endtask

    task automatic do_reset();
        quiet();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        bus.M0_HBUSREQ = 1'b1; bus.M1_HBUSREQ = 1'b1;
        bus.M0_HTRANS = 2'b10; bus.M1_HTRANS = 2'b10;
        HRESETn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (bus.M0_HGRANT !== 1'b1) begin miscompares++; $display("FAIL reset_m0_grant cyc%0d: got %b exp 1", i, bus.M0_HGRANT); end
            vectors++; if (bus.M1_HGRANT !== 1'b0) begin miscompares++; $display("FAIL reset_m1_grant cyc%0d: got %b exp 0", i, bus.M1_HGRANT); end
            vectors++; if (bus.HMASTER !== 1'b0) begin miscompares++; $display("FAIL reset_hmaster cyc%0d: got %b exp 0", i, bus.HMASTER); end
            vectors++; if (bus.HTRANS !== 2'b00) begin miscompares++; $display("FAIL reset_htrans cyc%0d: got %b exp 00", i, bus.HTRANS); end
        end
        vectors++; if (bus.M1_HRDATA !== 32'hA5A5_0000) begin miscompares++; $display("FAIL hrdata_bcast: got %h exp a5a50000", bus.M1_HRDATA); end
        bus.HREADY = 1'b0;
        #1;
        vectors++; if (bus.M0_HREADY !== 1'b0) begin miscompares++; $display("FAIL hready_bcast: got %b exp 0", bus.M0_HREADY); end
        HRESETn = 1'b1;
    endtask

    task automatic test_handover();
        do_reset();
        bus.M1_HBUSREQ = 1'b1; bus.M1_HTRANS = 2'b10; bus.M1_HADDR = 32'h2000_0000;
        bus.M1_HWRITE = 1'b1; bus.M1_HWDATA = 32'hDEAD_BEEF;
        tick();
        vectors++; if (bus.M1_HGRANT !== 1'b1) begin miscompares++; $display("FAIL ho_m1_grant: got %b exp 1", bus.M1_HGRANT); end
        vectors++; if (bus.HMASTER !== 1'b0) begin miscompares++; $display("FAIL ho_hmaster_e1: got %b exp 0", bus.HMASTER); end
        tick();
        vectors++; if (bus.HADDR !== 32'h2000_0000) begin miscompares++; $display("FAIL ho_haddr: got %h exp 20000000", bus.HADDR); end
        vectors++; if (bus.HMASTER !== 1'b1) begin miscompares++; $display("FAIL ho_hmaster_e2: got %b exp 1", bus.HMASTER); end
        vectors++; if (bus.HWRITE !== 1'b1) begin miscompares++; $display("FAIL ho_hwrite: got %b exp 1", bus.HWRITE); end
        vectors++; if (bus.HWDATA !== 32'h1111_1111) begin miscompares++; $display("FAIL ho_hwdata_e2: got %h exp 11111111", bus.HWDATA); end
        tick();
        vectors++; if (bus.HWDATA !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ho_hwdata_e3: got %h exp deadbeef", bus.HWDATA); end
    endtask

    task automatic test_burst();
        logic [31:0] addrs [4];
        logic [1:0]  trans [4];
        addrs = '{32'h100, 32'h104, 32'h108, 32'h10C};
        trans = '{2'b10, 2'b11, 2'b11, 2'b11};
        do_reset();
        bus.M0_HBUSREQ = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.M0_HADDR = addrs[i]; bus.M0_HTRANS = trans[i];
            bus.M1_HBUSREQ = (i > 0); bus.M1_HTRANS = 2'b10; bus.M1_HADDR = 32'h3000;
            tick();
            vectors++; if (bus.M1_HGRANT !== 1'b0) begin miscompares++; $display("FAIL burst_m1_grant beat%0d: got %b exp 0", i, bus.M1_HGRANT); end
            vectors++; if (bus.HMASTER !== 1'b0 || bus.HADDR !== addrs[i]) begin miscompares++; $display("FAIL burst_addr beat%0d: got m%0d %h exp m0 %h", i, bus.HMASTER, bus.HADDR, addrs[i]); end
        end
        bus.M0_HTRANS = 2'b00; bus.M0_HBUSREQ = 1'b0;
        tick();
        vectors++; if (bus.M1_HGRANT !== 1'b1) begin miscompares++; $display("FAIL burst_m1_grant_after: got %b exp 1", bus.M1_HGRANT); end
        tick();
        vectors++; if (bus.HMASTER !== 1'b1 || bus.HADDR !== 32'h3000) begin miscompares++; $display("FAIL burst_m1_addr: got m%0d %h exp m1 00003000", bus.HMASTER, bus.HADDR); end
    endtask

    task automatic test_wait();
        do_reset();
        bus.M1_HBUSREQ = 1'b1; bus.M1_HTRANS = 2'b10; bus.M1_HADDR = 32'h2000_0040;
        bus.M1_HWRITE = 1'b1; bus.M1_HWDATA = 32'hCAFE_0001;
        tick();
        tick();
        bus.M0_HBUSREQ = 1'b1; bus.M0_HTRANS = 2'b10; bus.M0_HADDR = 32'h200;
        tick();
        bus.M1_HTRANS = 2'b00; bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.M0_HGRANT !== 1'b1) begin miscompares++; $display("FAIL wait_grant cyc%0d: got %b exp 1", i, bus.M0_HGRANT); end
            vectors++; if (bus.HMASTER !== 1'b1) begin miscompares++; $display("FAIL wait_hmaster cyc%0d: got %b exp 1", i, bus.HMASTER); end
            vectors++; if (bus.HWDATA !== 32'hCAFE_0001) begin miscompares++; $display("FAIL wait_hwdata cyc%0d: got %h exp cafe0001", i, bus.HWDATA); end
        end
        bus.HREADY = 1'b1;
        tick();
        vectors++; if (bus.HMASTER !== 1'b0 || bus.HADDR !== 32'h200) begin miscompares++; $display("FAIL wait_m0_addr: got m%0d %h exp m0 00000200", bus.HMASTER, bus.HADDR); end
        vectors++; if (bus.HTRANS !== 2'b10) begin miscompares++; $display("FAIL wait_m0_htrans: got %b exp 10", bus.HTRANS); end
        vectors++; if (bus.HWDATA !== 32'hCAFE_0001) begin miscompares++; $display("FAIL wait_hwdata_after: got %h exp cafe0001", bus.HWDATA); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_own;
        exp_own = 4'b1010;
        do_reset();
        bus.M0_HBUSREQ = 1'b1; bus.M1_HBUSREQ = 1'b1;
        bus.M0_HTRANS = 2'b10; bus.M1_HTRANS = 2'b10;
        bus.M0_HADDR = 32'h0000_0A00; bus.M1_HADDR = 32'h0000_0B00;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (bus.HMASTER !== exp_own[i]) begin miscompares++; $display("FAIL rr_owner edge%0d: got %b exp %b", i + 1, bus.HMASTER, exp_own[i]); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        bus.M0_HBUSREQ = 1'b1; bus.M1_HBUSREQ = 1'b1; bus.M0_HLOCK = 1'b1;
        bus.M0_HTRANS = 2'b10; bus.M1_HTRANS = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (bus.HMASTER !== 1'b0 || bus.M1_HGRANT !== 1'b0) begin miscompares++; $display("FAIL lock_owner xfer%0d: got m%0d g1=%b exp m0 g1=0", i, bus.HMASTER, bus.M1_HGRANT); end
            vectors++; if (bus.HMASTLOCK !== 1'b1) begin miscompares++; $display("FAIL lock_hmastlock xfer%0d: got %b exp 1", i, bus.HMASTLOCK); end
        end
        bus.M0_HLOCK = 1'b0;
        tick();
        vectors++; if (bus.M1_HGRANT !== 1'b1 || bus.HMASTLOCK !== 1'b0) begin miscompares++; $display("FAIL lock_release: got g1=%b lock=%b exp g1=1 lock=0", bus.M1_HGRANT, bus.HMASTLOCK); end
    endtask

    task automatic test_park();
        do_reset();
        bus.M1_HBUSREQ = 1'b1;
        tick();
        bus.M1_HBUSREQ = 1'b0;
        tick();
        vectors++; if (bus.M0_HGRANT !== 1'b1) begin miscompares++; $display("FAIL park_default: got %b exp 1", bus.M0_HGRANT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.M1_HBUSREQ = 1'b1; bus.M1_HLOCK = 1'b1; bus.M1_HTRANS = 2'b10;
        bus.M1_HWRITE = 1'b1; bus.M1_HWDATA = 32'h5555_AAAA; bus.M0_HTRANS = 2'b10;
        tick();
        tick();
        vectors++; if (bus.HMASTLOCK !== 1'b1) begin miscompares++; $display("FAIL mid_lock_set: got %b exp 1", bus.HMASTLOCK); end
        tick();
        vectors++; if (bus.HWDATA !== 32'h5555_AAAA) begin miscompares++; $display("FAIL mid_dataphase: got %h exp 5555aaaa", bus.HWDATA); end
        HRESETn = 1'b0;
        tick();
        vectors++; if (bus.HMASTER !== 1'b0 || bus.M0_HGRANT !== 1'b1) begin miscompares++; $display("FAIL mid_reset_owner: got m%0d g0=%b exp m0 g0=1", bus.HMASTER, bus.M0_HGRANT); end
        vectors++; if (bus.HTRANS !== 2'b00 || bus.HMASTLOCK !== 1'b0) begin miscompares++; $display("FAIL mid_reset_idle: got trans=%b lock=%b exp 00 0", bus.HTRANS, bus.HMASTLOCK); end
        vectors++; if (bus.HWDATA !== 32'h1111_1111) begin miscompares++; $display("FAIL mid_reset_hwdata: got %h exp 11111111", bus.HWDATA); end
        HRESETn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_handover();
        test_burst();
        test_wait();
        test_round_robin();
        test_lock();
        test_park();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
